// File: rtl/sdram_burst_scheduler.sv
// Burst scheduler for the camera frame buffer: arbitrates four port FIFOs
// (two pixel writers, two VGA readers) and issues one SDRAM burst at a time.
module sdram_burst_scheduler #(
  parameter int unsigned ADDR_W      = 23,
  parameter int unsigned LEN_W       = 8,
  parameter int unsigned USED_W      = 9,
  parameter int unsigned FIFO_DEPTH  = 512,
  parameter int unsigned BURST_LEN   = 80,
  parameter int unsigned BUF0_BASE   = 0,
  parameter int unsigned BUF1_BASE   = 32'h0010_0000,
  parameter int unsigned FRAME_WORDS = 307200,
  parameter int unsigned RD_LOW_MARK = 128
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iLOAD,
  input  logic              iRD_EN,
  input  logic [USED_W-1:0] iWR1_USED,
  input  logic [USED_W-1:0] iWR2_USED,
  input  logic [USED_W-1:0] iRD1_USED,
  input  logic [USED_W-1:0] iRD2_USED,
  input  logic              iCMD_ACK,
  input  logic              iCMD_DONE,
  output logic              oCMD_VALID,
  output logic              oCMD_WRITE,
  output logic [1:0]        oCMD_PORT,
  output logic [ADDR_W-1:0] oCMD_ADDR,
  output logic [LEN_W-1:0]  oCMD_LEN,
  output logic              oBUSY,
  output logic              oWR_FRAME
);

  localparam int unsigned SUM_W = ADDR_W + 1;

  localparam logic [USED_W-1:0] WR_MIN  = USED_W'(BURST_LEN);
  localparam logic [USED_W-1:0] RD_MAX  = USED_W'(FIFO_DEPTH - BURST_LEN);
  localparam logic [USED_W-1:0] RD_LOW  = USED_W'(RD_LOW_MARK);
  localparam logic [ADDR_W-1:0] BASE0   = ADDR_W'(BUF0_BASE);
  localparam logic [ADDR_W-1:0] BASE1   = ADDR_W'(BUF1_BASE);
  localparam logic [LEN_W-1:0]  LEN_VAL = LEN_W'(BURST_LEN);
  localparam logic [SUM_W-1:0]  LEN_SUM = SUM_W'(BURST_LEN);
  localparam logic [SUM_W-1:0]  FRM_SUM = SUM_W'(FRAME_WORDS);

  // Index order is port number: WR1, WR2, RD1, RD2.
  localparam logic [3:0][ADDR_W-1:0] PTR_RST = {BASE1, BASE0, BASE1, BASE0};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [3:0][ADDR_W-1:0]    ptr_q, ptr_d;
  logic [1:0]                last_q, last_d;
  logic                      load_pend_q, load_pend_d;
  logic                      cmd_valid_q, cmd_valid_d;
  logic                      cmd_write_q, cmd_write_d;
  logic [1:0]                cmd_port_q, cmd_port_d;
  logic [ADDR_W-1:0]         cmd_addr_q, cmd_addr_d;
  logic [LEN_W-1:0]          cmd_len_q, cmd_len_d;
  logic                      busy_q, busy_d;
  logic                      frame_q, frame_d;

  logic [3:0]                elig_c;
  logic                      urg_rd1_c, urg_rd2_c;
  logic                      gnt_any_c;
  logic [1:0]                gnt_port_c;
  logic [1:0]                rr_idx_c;
  logic                      rr_found_c;
  logic [ADDR_W-1:0]         cur_base_c;
  logic [SUM_W-1:0]          adv_sum_c;
  logic [SUM_W-1:0]          wrap_lim_c;
  logic                      wrap_c;
  logic [ADDR_W-1:0]         adv_ptr_c;

  // Per-port eligibility and read urgency.
  always_comb begin
    elig_c[0] = (iWR1_USED >= WR_MIN);
    elig_c[1] = (iWR2_USED >= WR_MIN);
    elig_c[2] = iRD_EN && (iRD1_USED <= RD_MAX);
    elig_c[3] = iRD_EN && (iRD2_USED <= RD_MAX);
    urg_rd1_c = elig_c[2] && (iRD1_USED < RD_LOW);
    urg_rd2_c = elig_c[3] && (iRD2_USED < RD_LOW);
  end

  // Urgent reads win outright, otherwise round-robin after the last grant.
  always_comb begin
    gnt_any_c  = |elig_c;
    gnt_port_c = 2'd0;
    rr_idx_c   = 2'd0;
    rr_found_c = 1'b0;
    if (urg_rd1_c) begin
      gnt_port_c = 2'd2;
    end else if (urg_rd2_c) begin
      gnt_port_c = 2'd3;
    end else begin
      for (int i = 1; i <= 4; i++) begin
        rr_idx_c = last_q + 2'(i);
        if (!rr_found_c && elig_c[rr_idx_c]) begin
          gnt_port_c = rr_idx_c;
          rr_found_c = 1'b1;
        end
      end
    end
  end

  // Pointer advance for the port of the burst in flight, wrapping at frame end.
  always_comb begin
    cur_base_c = cmd_port_q[0] ? BASE1 : BASE0;
    adv_sum_c  = {1'b0, ptr_q[cmd_port_q]} + LEN_SUM;
    wrap_lim_c = {1'b0, cur_base_c} + FRM_SUM;
    wrap_c     = (adv_sum_c >= wrap_lim_c);
    adv_ptr_c  = wrap_c ? cur_base_c : adv_sum_c[ADDR_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    last_d      = last_q;
    load_pend_d = load_pend_q;
    cmd_valid_d = cmd_valid_q;
    cmd_write_d = cmd_write_q;
    cmd_port_d  = cmd_port_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;
    frame_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (iLOAD) begin
          ptr_d = PTR_RST;
        end else if (gnt_any_c && !load_pend_q) begin
          state_d     = S_ISSUE;
          cmd_valid_d = 1'b1;
          cmd_port_d  = gnt_port_c;
          cmd_write_d = ~gnt_port_c[1];
          cmd_addr_d  = ptr_q[gnt_port_c];
          cmd_len_d   = LEN_VAL;
          last_d      = gnt_port_c;
        end
      end
      S_ISSUE: begin
        if (iLOAD) load_pend_d = 1'b1;
        if (iCMD_ACK) begin
          cmd_valid_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (iCMD_DONE) begin
          state_d = S_IDLE;
          // A load seen during the burst (or with DONE) overrides its advance.
          if (load_pend_q || iLOAD) begin
            ptr_d       = PTR_RST;
            load_pend_d = 1'b0;
          end else begin
            ptr_d[cmd_port_q] = adv_ptr_c;
            frame_d           = wrap_c && (cmd_port_q == 2'd0);
          end
        end else if (iLOAD) begin
          load_pend_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= S_IDLE;
      ptr_q       <= PTR_RST;
      last_q      <= 2'd3;
      load_pend_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_port_q  <= 2'd0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
      busy_q      <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      last_q      <= last_d;
      load_pend_q <= load_pend_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_write_q <= cmd_write_d;
      cmd_port_q  <= cmd_port_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
      busy_q      <= busy_d;
      frame_q     <= frame_d;
    end
  end

  assign oCMD_VALID = cmd_valid_q;
  assign oCMD_WRITE = cmd_write_q;
  assign oCMD_PORT  = cmd_port_q;
  assign oCMD_ADDR  = cmd_addr_q;
  assign oCMD_LEN   = cmd_len_q;
  assign oBUSY      = busy_q;
  assign oWR_FRAME  = frame_q;

endmodule

// File: tb/tb_sdram_burst_scheduler.sv
// Directed bench for sdram_burst_scheduler with a command scoreboard.
module tb_sdram_burst_scheduler;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic        iLOAD;
  logic        iRD_EN;
  logic [8:0]  iWR1_USED, iWR2_USED, iRD1_USED, iRD2_USED;
  logic        iCMD_ACK, iCMD_DONE;
  logic        oCMD_VALID, oCMD_WRITE;
  logic [1:0]  oCMD_PORT;
  logic [22:0] oCMD_ADDR;
  logic [7:0]  oCMD_LEN;
  logic        oBUSY, oWR_FRAME;

  typedef struct packed {
    logic [1:0]  port;
    logic [22:0] addr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  sdram_burst_scheduler dut (
    .iCLK       (iCLK),
    .iRST_N     (iRST_N),
    .iLOAD      (iLOAD),
    .iRD_EN     (iRD_EN),
    .iWR1_USED  (iWR1_USED),
    .iWR2_USED  (iWR2_USED),
    .iRD1_USED  (iRD1_USED),
    .iRD2_USED  (iRD2_USED),
    .iCMD_ACK   (iCMD_ACK),
    .iCMD_DONE  (iCMD_DONE),
    .oCMD_VALID (oCMD_VALID),
    .oCMD_WRITE (oCMD_WRITE),
    .oCMD_PORT  (oCMD_PORT),
    .oCMD_ADDR  (oCMD_ADDR),
    .oCMD_LEN   (oCMD_LEN),
    .oBUSY      (oBUSY),
    .oWR_FRAME  (oWR_FRAME)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] p, input logic [22:0] a);
    exp_t e;
    e.port = p;
    e.addr = a;
    sb.push_back(e);
  endtask

  task automatic set_levels(input logic rd_en, input logic [8:0] w1, input logic [8:0] w2,
                            input logic [8:0] r1, input logic [8:0] r2);
    iRD_EN    = rd_en;
    iWR1_USED = w1;
    iWR2_USED = w2;
    iRD1_USED = r1;
    iRD2_USED = r2;
  endtask

  task automatic apply_reset();
    iRST_N    = 1'b0;
    iLOAD     = 1'b0;
    iCMD_ACK  = 1'b0;
    iCMD_DONE = 1'b0;
    repeat (2) @(negedge iCLK);
    iRST_N = 1'b1;
  endtask

  // Runs one burst from VALID to DONE; returns on the negedge after DONE (DUT in IDLE).
  task automatic do_burst(input int hold, input int load_mode, input bit exp_frame);
    exp_t e;
    for (int k = 0; k < 20 && oCMD_VALID !== 1'b1; k++) @(negedge iCLK);
    chk("valid", 32'(oCMD_VALID), 32'd1);
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    e = '0;
    if (sb.size() != 0) e = sb.pop_front();
    chk("port", 32'(oCMD_PORT), 32'(e.port));
    chk("write", 32'(oCMD_WRITE), 32'(e.port < 2'd2));
    chk("addr", 32'(oCMD_ADDR), 32'(e.addr));
    chk("len", 32'(oCMD_LEN), 32'd80);
    chk("busy_issue", 32'(oBUSY), 32'd1);
    for (int k = 0; k < hold; k++) begin
      iCMD_DONE = 1'b1;
      @(negedge iCLK);
      chk("hold_valid", 32'(oCMD_VALID), 32'd1);
      chk("hold_port", 32'(oCMD_PORT), 32'(e.port));
      chk("hold_addr", 32'(oCMD_ADDR), 32'(e.addr));
    end
    iCMD_DONE = 1'b0;
    iCMD_ACK  = 1'b1;
    @(negedge iCLK);
    iCMD_ACK = 1'b0;
    chk("valid_after_ack", 32'(oCMD_VALID), 32'd0);
    chk("busy_wait", 32'(oBUSY), 32'd1);
    if (load_mode == 1) begin
      iLOAD = 1'b1;
      @(negedge iCLK);
      iLOAD = 1'b0;
      chk("busy_load", 32'(oBUSY), 32'd1);
    end
    iCMD_DONE = 1'b1;
    if (load_mode == 2) iLOAD = 1'b1;
    @(negedge iCLK);
    iCMD_DONE = 1'b0;
    iLOAD     = 1'b0;
    chk("busy_idle", 32'(oBUSY), 32'd0);
    chk("wr_frame", 32'(oWR_FRAME), 32'(exp_frame));
  endtask

  initial begin
    // Reset state and single WR1 bursts
    set_levels(1'b0, 9'd80, 9'd0, 9'd0, 9'd0);
    iRST_N = 1'b0; iLOAD = 1'b0; iCMD_ACK = 1'b0; iCMD_DONE = 1'b0;
    repeat (2) @(negedge iCLK);
    chk("rst_valid", 32'(oCMD_VALID), 32'd0);
    chk("rst_busy", 32'(oBUSY), 32'd0);
    chk("rst_frame", 32'(oWR_FRAME), 32'd0);
    chk("rst_port", 32'(oCMD_PORT), 32'd0);
    chk("rst_addr", 32'(oCMD_ADDR), 32'd0);
    chk("rst_len", 32'(oCMD_LEN), 32'd0);
    chk("rst_write", 32'(oCMD_WRITE), 32'd0);
    iRST_N = 1'b1;
    @(negedge iCLK);
    chk("first_latency", 32'(oCMD_VALID), 32'd1);
    push(2'd0, 23'd0);  do_burst(0, 0, 1'b0);
    push(2'd0, 23'd80); do_burst(0, 0, 1'b0);

    // Round-robin over all four ports
    set_levels(1'b1, 9'd100, 9'd100, 9'd300, 9'd300);
    apply_reset();
    push(2'd0, 23'd0);        do_burst(0, 0, 1'b0);
    push(2'd1, 23'h100000);   do_burst(0, 0, 1'b0);
    push(2'd2, 23'd0);        do_burst(0, 0, 1'b0);
    push(2'd3, 23'h100000);   do_burst(0, 0, 1'b0);
    push(2'd0, 23'd80);       do_burst(0, 0, 1'b0);

    // Urgent reads, RD1 before RD2, then round-robin resumes
    set_levels(1'b1, 9'd80, 9'd0, 9'd60, 9'd50);
    apply_reset();
    push(2'd2, 23'd0);        do_burst(0, 0, 1'b0);
    iRD1_USED = 9'd140;
    push(2'd3, 23'h100000);   do_burst(0, 0, 1'b0);
    iRD2_USED = 9'd130;
    push(2'd0, 23'd0);        do_burst(0, 0, 1'b0);

    // Full frame on WR1 (pulse), then full frame on WR2 (no pulse)
    set_levels(1'b0, 9'd80, 9'd0, 9'd0, 9'd0);
    apply_reset();
    for (int i = 0; i < 3840; i++) begin
      push(2'd0, 23'(i * 80));
      do_burst(0, 0, (i == 3839));
    end
    @(negedge iCLK);
    chk("frame_one_cycle", 32'(oWR_FRAME), 32'd0);
    push(2'd0, 23'd0);        do_burst(0, 0, 1'b0);
    iWR1_USED = 9'd0;
    iWR2_USED = 9'd80;
    for (int i = 0; i < 3840; i++) begin
      push(2'd1, 23'(32'h100000 + i * 80));
      do_burst(0, 0, 1'b0);
    end
    push(2'd1, 23'h100000);   do_burst(0, 0, 1'b0);

    // Pointer reload during WAIT, coincident with DONE, and in IDLE
    set_levels(1'b0, 9'd80, 9'd80, 9'd0, 9'd0);
    apply_reset();
    push(2'd0, 23'd0);        do_burst(0, 0, 1'b0);
    push(2'd1, 23'h100000);   do_burst(0, 0, 1'b0);
    push(2'd0, 23'd80);       do_burst(0, 0, 1'b0);
    push(2'd1, 23'h100050);   do_burst(0, 0, 1'b0);
    push(2'd0, 23'd160);      do_burst(0, 1, 1'b0);
    push(2'd1, 23'h100000);   do_burst(0, 0, 1'b0);
    push(2'd0, 23'd0);        do_burst(0, 0, 1'b0);
    push(2'd1, 23'h100050);   do_burst(0, 2, 1'b0);
    push(2'd0, 23'd0);        do_burst(0, 0, 1'b0);
    push(2'd1, 23'h100000);   do_burst(0, 0, 1'b0);
    iLOAD = 1'b1;
    @(negedge iCLK);
    iLOAD = 1'b0;
    chk("idle_load_no_grant", 32'(oCMD_VALID), 32'd0);
    push(2'd0, 23'd0);        do_burst(0, 0, 1'b0);
    push(2'd1, 23'h100000);   do_burst(0, 0, 1'b0);

    // Stray DONE/ACK in IDLE, ACK withheld with DONE pulses in ISSUE
    set_levels(1'b0, 9'd0, 9'd0, 9'd0, 9'd0);
    apply_reset();
    iCMD_DONE = 1'b1;
    iCMD_ACK  = 1'b1;
    @(negedge iCLK);
    iCMD_DONE = 1'b0;
    iCMD_ACK  = 1'b0;
    chk("idle_stray_valid", 32'(oCMD_VALID), 32'd0);
    chk("idle_stray_busy", 32'(oBUSY), 32'd0);
    iWR1_USED = 9'd80;
    push(2'd0, 23'd0);        do_burst(10, 0, 1'b0);
    push(2'd0, 23'd80);       do_burst(0, 0, 1'b0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
